// File: rtl/pipelined_control_unit.sv
// RV32I control unit: decodes the instruction in ID and carries the control bundle
// through PIPE_STAGES registered stages, with stall, flush and load-use interlock.
module pipelined_control_unit #(
   parameter int unsigned PIPE_STAGES = 3,
   parameter bit          ENABLE_EXT  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr_i,
   input  logic        instr_valid_i,
   output logic        instr_ready_o,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        ex_valid_o,
   output logic [3:0]  ex_alu_ctrl_o,
   output logic        ex_alu_src_o,
   output logic [2:0]  ex_imm_src_o,
   output logic [2:0]  ex_br_cond_o,
   output logic        ex_branch_o,
   output logic        ex_jal_o,
   output logic        ex_jalr_o,
   output logic [4:0]  ex_rd_o,
   output logic        mem_write_o,
   output logic        wb_reg_write_o,
   output logic        wb_result_src_o,
   output logic [4:0]  wb_rd_o,
   output logic        illegal_o
);

   localparam int unsigned MEM_IDX = (PIPE_STAGES > 1) ? 1 : 0;
   localparam int unsigned WB_IDX  = PIPE_STAGES - 1;

   typedef struct packed {
      logic       valid;
      logic [3:0] alu_ctrl;
      logic       alu_src;
      logic [2:0] imm_src;
      logic [2:0] br_cond;
      logic       branch;
      logic       jal;
      logic       jalr;
      logic [4:0] rd;
      logic       mem_write;
      logic       reg_write;
      logic       result_src;
   } ctrl_t;

   ctrl_t pipe_q [PIPE_STAGES];
   ctrl_t dec;
   ctrl_t stage0_d;
   logic  illegal_q, illegal_d;
   logic  illegal, uses_rs2, hazard, accept;

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic       f7_zero, f7_alt;

   assign opcode  = instr_i[6:0];
   assign funct3  = instr_i[14:12];
   assign funct7  = instr_i[31:25];
   assign f7_zero = (funct7 == 7'b0000000);
   assign f7_alt  = (funct7 == 7'b0100000);

   function automatic logic [3:0] logic_op(input logic [2:0] f3);
      case (f3)
         3'b001:  logic_op = 4'b0111;
         3'b100:  logic_op = 4'b1010;
         3'b110:  logic_op = 4'b1011;
         3'b111:  logic_op = 4'b1100;
         default: logic_op = 4'b0000;
      endcase
   endfunction

   always_comb begin
      dec       = '0;
      illegal   = 1'b0;
      uses_rs2  = 1'b0;
      dec.valid = 1'b1;
      dec.rd    = instr_i[11:7];
      case (opcode)
         7'b0110011: begin
            uses_rs2      = 1'b1;
            dec.reg_write = 1'b1;
            case (funct3)
               3'b000: begin
                  dec.alu_ctrl = f7_alt ? 4'b1000 : 4'b0000;
                  illegal      = !(f7_zero || f7_alt);
               end
               3'b101: begin
                  dec.alu_ctrl = f7_alt ? 4'b1110 : 4'b1001;
                  illegal      = !(f7_zero || (f7_alt && ENABLE_EXT));
               end
               3'b010: begin
                  dec.alu_ctrl = 4'b1111;
                  illegal      = !(f7_zero && ENABLE_EXT);
               end
               3'b011:  illegal = 1'b1;
               default: begin
                  dec.alu_ctrl = logic_op(funct3);
                  illegal      = !f7_zero;
               end
            endcase
         end
         7'b0010011: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            case (funct3)
               3'b000:  dec.alu_ctrl = 4'b0000;
               3'b010: begin
                  dec.alu_ctrl = 4'b1111;
                  illegal      = !ENABLE_EXT;
               end
               3'b011:  illegal = 1'b1;
               3'b101: begin
                  dec.alu_ctrl = instr_i[30] ? 4'b1110 : 4'b1001;
                  illegal      = instr_i[30] && !ENABLE_EXT;
               end
               default: dec.alu_ctrl = logic_op(funct3);
            endcase
         end
         7'b0000011: begin
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.result_src = 1'b1;
            dec.alu_ctrl   = (funct3 == 3'b100) ? 4'b0101 : 4'b0000;
            illegal        = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
         end
         7'b0100011: begin
            uses_rs2      = 1'b1;
            dec.rd        = '0;
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = 3'b010;
            dec.alu_ctrl  = 4'b0110;
            illegal       = (funct3 > 3'b010);
         end
         7'b1100011: begin
            uses_rs2     = 1'b1;
            dec.rd       = '0;
            dec.branch   = 1'b1;
            dec.imm_src  = 3'b011;
            dec.br_cond  = funct3;
            dec.alu_ctrl = (funct3 == 3'b001) ? 4'b0001 : 4'b1101;
            illegal      = (funct3[2:1] == 2'b01);
         end
         7'b0110111: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = 3'b001;
            dec.alu_ctrl  = 4'b0100;
         end
         7'b0010111: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = 3'b001;
         end
         7'b1101111: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = 3'b100;
            dec.jal       = 1'b1;
            dec.alu_ctrl  = 4'b0010;
         end
         7'b1100111: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.jalr      = 1'b1;
            dec.alu_ctrl  = 4'b0011;
            illegal       = (funct3 != 3'b000);
         end
         default: illegal = 1'b1;
      endcase
      if (dec.rd == 5'd0) dec.reg_write = 1'b0;
   end

   // Load in EX whose result the ID instruction needs: hold ID, bubble EX.
   assign hazard = pipe_q[0].valid && pipe_q[0].result_src && (pipe_q[0].rd != 5'd0) &&
                   ((pipe_q[0].rd == instr_i[19:15]) ||
                    (uses_rs2 && (pipe_q[0].rd == instr_i[24:20])));

   assign instr_ready_o = !stall_i && !hazard && !flush_i;
   assign accept        = instr_valid_i && instr_ready_o;
   assign stage0_d      = (accept && !illegal) ? dec : '0;
   assign illegal_d     = accept && illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < PIPE_STAGES; k++) pipe_q[k] <= '0;
         illegal_q <= 1'b0;
      end else begin
         if (flush_i)       pipe_q[0] <= '0;
         else if (!stall_i) pipe_q[0] <= stage0_d;
         for (int unsigned k = 1; k < PIPE_STAGES; k++)
            if (!stall_i) pipe_q[k] <= pipe_q[k-1];
         illegal_q <= illegal_d;
      end
   end

   assign ex_valid_o      = pipe_q[0].valid;
   assign ex_alu_ctrl_o   = pipe_q[0].alu_ctrl;
   assign ex_alu_src_o    = pipe_q[0].alu_src;
   assign ex_imm_src_o    = pipe_q[0].imm_src;
   assign ex_br_cond_o    = pipe_q[0].br_cond;
   assign ex_branch_o     = pipe_q[0].branch;
   assign ex_jal_o        = pipe_q[0].jal;
   assign ex_jalr_o       = pipe_q[0].jalr;
   assign ex_rd_o         = pipe_q[0].rd;
   assign mem_write_o     = pipe_q[MEM_IDX].valid && pipe_q[MEM_IDX].mem_write;
   assign wb_reg_write_o  = pipe_q[WB_IDX].valid && pipe_q[WB_IDX].reg_write;
   assign wb_result_src_o = pipe_q[WB_IDX].result_src;
   assign wb_rd_o         = pipe_q[WB_IDX].rd;
   assign illegal_o       = illegal_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench: default 3-stage unit plus a 1-stage, no-extension unit on shared inputs.
module tb_pipelined_control_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        valid, stall, flush;

   logic        rdy, exv, alusrc, br, jal, jalr, memw, wbw, wbres, ill;
   logic [3:0]  alu;
   logic [2:0]  imm, brc;
   logic [4:0]  exrd, wbrd;

   logic        rdy2, exv2, alusrc2, br2, jal2, jalr2, memw2, wbw2, wbres2, ill2;
   logic [3:0]  alu2;
   logic [2:0]  imm2, brc2;
   logic [4:0]  exrd2, wbrd2;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   pipelined_control_unit #(.PIPE_STAGES(3), .ENABLE_EXT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(valid),
      .instr_ready_o(rdy), .stall_i(stall), .flush_i(flush),
      .ex_valid_o(exv), .ex_alu_ctrl_o(alu), .ex_alu_src_o(alusrc), .ex_imm_src_o(imm),
      .ex_br_cond_o(brc), .ex_branch_o(br), .ex_jal_o(jal), .ex_jalr_o(jalr),
      .ex_rd_o(exrd), .mem_write_o(memw), .wb_reg_write_o(wbw),
      .wb_result_src_o(wbres), .wb_rd_o(wbrd), .illegal_o(ill));

   pipelined_control_unit #(.PIPE_STAGES(1), .ENABLE_EXT(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(valid),
      .instr_ready_o(rdy2), .stall_i(stall), .flush_i(flush),
      .ex_valid_o(exv2), .ex_alu_ctrl_o(alu2), .ex_alu_src_o(alusrc2), .ex_imm_src_o(imm2),
      .ex_br_cond_o(brc2), .ex_branch_o(br2), .ex_jal_o(jal2), .ex_jalr_o(jalr2),
      .ex_rd_o(exrd2), .mem_write_o(memw2), .wb_reg_write_o(wbw2),
      .wb_result_src_o(wbres2), .wb_rd_o(wbrd2), .illegal_o(ill2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic f);
      instr = i;
      valid = v;
      stall = s;
      flush = f;
      #1;
   endtask

   typedef struct {
      logic [31:0] ins;
      logic [3:0]  alu;
      logic        src;
      logic [2:0]  imm;
   } vec_t;

   vec_t tv [12];

   initial begin
      tv = '{
         '{32'h002081B3, 4'b0000, 1'b0, 3'b000},  // ADD
         '{32'h40208233, 4'b1000, 1'b0, 3'b000},  // SUB
         '{32'h002091B3, 4'b0111, 1'b0, 3'b000},  // SLL
         '{32'h0050C193, 4'b1010, 1'b1, 3'b000},  // XORI
         '{32'h40315093, 4'b1110, 1'b1, 3'b000},  // SRAI
         '{32'h0010A193, 4'b1111, 1'b1, 3'b000},  // SLTI
         '{32'h0000C183, 4'b0101, 1'b1, 3'b000},  // LBU
         '{32'h123452B7, 4'b0100, 1'b1, 3'b001},  // LUI
         '{32'h008000EF, 4'b0010, 1'b1, 3'b100},  // JAL
         '{32'h000100E7, 4'b0011, 1'b1, 3'b000},  // JALR
         '{32'h00209063, 4'b0001, 1'b0, 3'b011},  // BNE
         '{32'h0020A023, 4'b0110, 1'b1, 3'b010}   // SW
      };

      rst_n = 1'b0;
      instr = '0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ex_valid", exv, 0);
      chk("rst_wb_regw", wbw, 0);
      chk("rst_alu", alu, 0);
      chk("rst_illegal", ill, 0);
      rst_n = 1'b1;

      // ADD x3,x1,x2 through the pipe
      drive(32'h002081B3, 1, 0, 0);
      chk("add_ready", rdy, 1);
      tick();
      chk("add_ex_valid", exv, 1);
      chk("add_ex_alu", alu, 4'b0000);
      chk("add_ex_rd", exrd, 3);
      chk("add_p1_wb_regw", wbw2, 1);
      chk("add_p1_wb_rd", wbrd2, 3);
      drive(0, 0, 0, 0);
      tick();
      chk("add_bubble", exv, 0);
      tick();
      chk("add_wb_regw", wbw, 1);
      chk("add_wb_rd", wbrd, 3);
      tick();
      chk("add_wb_gone", wbw, 0);

      // decode table
      foreach (tv[n]) begin
         drive(tv[n].ins, 1, 0, 0);
         tick();
         chk($sformatf("dec%0d_valid", n), exv, 1);
         chk($sformatf("dec%0d_alu", n), alu, tv[n].alu);
         chk($sformatf("dec%0d_src", n), alusrc, tv[n].src);
         chk($sformatf("dec%0d_imm", n), imm, tv[n].imm);
         if (n == 4) begin
            chk("srai_noext_illegal", ill2, 1);
            chk("srai_noext_bubble", exv2, 0);
            chk("srai_ext_legal", ill, 0);
         end
         if (n == 11) chk("sw_p1_memw", memw2, 1);
         drive(0, 0, 0, 0);
         tick();
         if (n == 11) chk("sw_memw", memw, 1);
      end

      // load-use interlock
      drive(32'h0000A283, 1, 0, 0);
      tick();
      chk("lw_ex_rd", exrd, 5);
      drive(32'h00728333, 1, 0, 0);
      chk("lu_ready_low", rdy, 0);
      tick();
      chk("lu_bubble", exv, 0);
      chk("lu_ready_back", rdy, 1);
      tick();
      chk("lu_add_ex", exv, 1);
      chk("lu_add_rd", exrd, 6);
      chk("lw_wb_res", wbres, 1);
      chk("lw_wb_rd", wbrd, 5);
      drive(0, 0, 0, 0);
      tick();
      drive(32'h0000A003, 1, 0, 0);
      tick();
      drive(32'h00000333, 1, 0, 0);
      chk("lw_x0_no_stall", rdy, 1);
      tick();
      chk("lw_x0_next_rd", exrd, 6);
      drive(0, 0, 0, 0);
      tick();
      chk("lw_x0_no_regw", wbw, 0);
      tick();

      // branch flush kills SW in ID
      drive(32'h00208063, 1, 0, 0);
      tick();
      chk("beq_branch", br, 1);
      chk("beq_alu", alu, 4'b1101);
      chk("beq_cond", brc, 0);
      drive(32'h0020A023, 1, 0, 1);
      chk("flush_ready", rdy, 0);
      tick();
      chk("flush_ex_valid", exv, 0);
      chk("flush_memw0", memw, 0);
      drive(0, 0, 0, 0);
      tick();
      chk("flush_memw1", memw, 0);
      tick();

      // 3-cycle stall mid-stream
      drive(32'h002081B3, 1, 0, 0);
      tick();
      drive(32'h00728333, 1, 0, 0);
      tick();
      chk("st_pre_rd", exrd, 6);
      drive(32'h0020E4B3, 1, 1, 0);
      chk("st_ready", rdy, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("st%0d_ex_rd", c), exrd, 6);
         chk($sformatf("st%0d_ex_valid", c), exv, 1);
         chk($sformatf("st%0d_wb_regw", c), wbw, 0);
      end
      drive(32'h0020E4B3, 1, 0, 0);
      chk("st_resume_ready", rdy, 1);
      tick();
      chk("st_or_rd", exrd, 9);
      chk("st_or_alu", alu, 4'b1011);
      chk("st_wb_a", wbrd, 3);
      drive(0, 0, 0, 0);
      tick();
      chk("st_bubble", exv, 0);
      chk("st_wb_b", wbrd, 6);
      tick();
      chk("st_wb_c", wbrd, 9);
      chk("st_wb_c_regw", wbw, 1);
      tick();
      chk("st_wb_done", wbw, 0);

      // illegal opcode: single pulse, not repeated under stall
      drive(32'h0000007F, 1, 0, 0);
      tick();
      chk("ill_pulse", ill, 1);
      chk("ill_bubble", exv, 0);
      drive(32'h0000007F, 1, 1, 0);
      tick();
      chk("ill_no_repulse", ill, 0);
      drive(0, 0, 0, 0);
      tick();
      tick();
      chk("ill_no_regw", wbw, 0);
      chk("ill_no_memw", memw, 0);

      // asynchronous reset mid-stream
      drive(32'h002081B3, 1, 0, 0);
      tick();
      chk("ar_pre", exv, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_ex_valid", exv, 0);
      chk("ar_ex_rd", exrd, 0);
      chk("ar_alu_src", alusrc, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(32'h002081B3, 1, 0, 0);
      tick();
      chk("ar_first_ex", exv, 1);
      chk("ar_first_rd", exrd, 3);
      drive(0, 0, 0, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
